axis_pattern_fifo_gen: RTL and testbench

Parametrised AXI-Stream test-pattern source with an integrated synchronous FIFO. It supersedes the fixed generator-plus-FIFO pairing.
- A packet FSM produces framed packets in one of four data modes (increment, decrement, rotate, constant) from a runtime seed and packet length.
- Packets are buffered in an internal FIFO of configurable depth and drained on an AXIS master port with full backpressure.
- Status counters expose FIFO fill level and completed packets.

---
 rtl/axis_pattern_fifo_gen_pkg.sv | 14 +
 rtl/axis_pattern_fifo_gen_if.sv | 15 +
 rtl/axis_pattern_fifo_gen_sync_fifo.sv | 63 ++++++
 rtl/axis_pattern_fifo_gen.sv | 126 ++++++++++++
 tb/tb_axis_pattern_fifo_gen.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pattern_fifo_gen_pkg.sv
// Shared encodings for the AXI-Stream pattern generator: data modes and FSM states.
package axis_pattern_fifo_gen_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_INC   = 2'd0;
  localparam mode_t MODE_DEC   = 2'd1;
  localparam mode_t MODE_ROT   = 2'd2;
  localparam mode_t MODE_CONST = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/axis_pattern_fifo_gen_if.sv
// AXI-Stream bundle carried between the pattern generator and its consumer.
interface axis_pattern_fifo_gen_if #(
  parameter int DATA_SIZE = 32
);

  logic [DATA_SIZE-1:0]   tdata;
  logic [DATA_SIZE/8-1:0] tstrb;
  logic                   tvalid;
  logic                   tlast;
  logic                   tready;

  modport master (output tdata, output tstrb, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tstrb, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_pattern_fifo_gen_sync_fifo.sv
// Single-clock FIFO with occupancy counter; head word is visible combinationally.
module axis_sync_fifo #(
  parameter int WIDTH      = 33,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  srst_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LEVEL_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [ADDR_WIDTH:0]   level_reg;
  logic                  wr_fire;
  logic                  rd_fire;

  assign full    = (level_reg == LEVEL_FULL);
  assign empty   = (level_reg == '0);
  assign level   = level_reg;
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;

  // Head is read asynchronously so a beat is on the bus the cycle after it is written;
  // forced to zero when empty so idle outputs read as 0.
  assign rd_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_WIDTH'(1);
      end
      if (rd_fire) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_WIDTH'(1);
      end
      case ({wr_fire, rd_fire})
        2'b10:   level_reg <= level_reg + (ADDR_WIDTH + 1)'(1);
        2'b01:   level_reg <= level_reg - (ADDR_WIDTH + 1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/axis_pattern_fifo_gen.sv
// AXI-Stream test-pattern source: packet FSM feeding an internal FIFO drained on an AXIS master.
module axis_pattern_fifo_gen
  import axis_pattern_fifo_gen_pkg::*;
#(
  parameter int DATA_SIZE  = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  m00_axis_aclk,
  input  logic                  m00_axis_aresetn,
  input  logic                  m00_axis_enable,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_SIZE-1:0]  cfg_seed,
  input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
  axis_pattern_fifo_gen_if.master m00_axis,
  output logic [ADDR_WIDTH:0]   stat_fifo_level,
  output logic [CNT_WIDTH-1:0]  stat_pkt_count,
  output logic                  busy
);

  localparam int STRB_WIDTH = DATA_SIZE / 8;

  logic [0:0]           state_reg;
  mode_t                mode_reg;
  logic [LEN_WIDTH-1:0] len_reg;
  logic [DATA_SIZE-1:0] data_reg;
  logic [LEN_WIDTH-1:0] beat_cnt_reg;
  logic [CNT_WIDTH-1:0] pkt_count_reg;

  logic [LEN_WIDTH-1:0]  eff_len;
  logic                  last_beat;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  wr_fire;
  logic                  tvalid;
  logic [DATA_SIZE:0]    head_word;
  logic [STRB_WIDTH-1:0] strb;

  function automatic logic [DATA_SIZE-1:0] next_pattern(input mode_t mode,
                                                        input logic [DATA_SIZE-1:0] d);
    logic [DATA_SIZE-1:0] r;
    case (mode)
      MODE_INC: r = d + DATA_SIZE'(1);
      MODE_DEC: r = d - DATA_SIZE'(1);
      MODE_ROT: r = {d[DATA_SIZE-2:0], d[DATA_SIZE-1]};
      default:  r = d;
    endcase
    return r;
  endfunction

  assign eff_len   = (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;
  assign last_beat = (beat_cnt_reg == len_reg - LEN_WIDTH'(1));
  assign wr_fire   = (state_reg == ST_RUN) && !fifo_full;

  always_ff @(posedge m00_axis_aclk) begin
    if (!m00_axis_aresetn) begin
      state_reg     <= ST_IDLE;
      mode_reg      <= MODE_INC;
      len_reg       <= '0;
      data_reg      <= '0;
      beat_cnt_reg  <= '0;
      pkt_count_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (m00_axis_enable) begin
            mode_reg     <= cfg_mode;
            len_reg      <= eff_len;
            data_reg     <= cfg_seed;
            beat_cnt_reg <= '0;
            state_reg    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (wr_fire) begin
            data_reg <= next_pattern(mode_reg, data_reg);
            if (last_beat) begin
              beat_cnt_reg  <= '0;
              pkt_count_reg <= pkt_count_reg + CNT_WIDTH'(1);
              // Back-to-back packets keep the running data value; only mode and length refresh.
              if (m00_axis_enable) begin
                mode_reg <= cfg_mode;
                len_reg  <= eff_len;
              end else begin
                state_reg <= ST_IDLE;
              end
            end else begin
              beat_cnt_reg <= beat_cnt_reg + LEN_WIDTH'(1);
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  axis_sync_fifo #(
    .WIDTH      (DATA_SIZE + 1),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk     (m00_axis_aclk),
    .srst_n  (m00_axis_aresetn),
    .wr_en   (state_reg == ST_RUN),
    .wr_data ({data_reg, last_beat}),
    .full    (fifo_full),
    .rd_en   (tvalid && m00_axis.tready),
    .rd_data (head_word),
    .empty   (fifo_empty),
    .level   (stat_fifo_level)
  );

  assign tvalid = !fifo_empty;

  for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_strb
    assign strb[gi] = tvalid;
  end

  assign m00_axis.tvalid = tvalid;
  assign m00_axis.tdata  = head_word[DATA_SIZE:1];
  assign m00_axis.tlast  = head_word[0];
  assign m00_axis.tstrb  = strb;
  assign stat_pkt_count  = pkt_count_reg;
  assign busy            = (state_reg == ST_RUN);

endmodule

// File: tb/tb_axis_pattern_fifo_gen.sv
// Randomised bench for axis_pattern_fifo_gen against a packet-level expected-beat queue.
module tb_axis_pattern_fifo_gen;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int LW    = 16;
  localparam int CW    = 32;
  localparam int DEPTH = 2 ** AW;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk;
  logic          aresetn;
  logic          enable;
  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_seed;
  logic [LW-1:0] cfg_pkt_len;
  logic [AW:0]   level;
  logic [CW-1:0] pkt_count;
  logic          busy;

  axis_pattern_fifo_gen_if #(.DATA_SIZE(DW)) axis ();

  axis_pattern_fifo_gen #(
    .DATA_SIZE  (DW),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW),
    .CNT_WIDTH  (CW)
  ) dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (aresetn),
    .m00_axis_enable  (enable),
    .cfg_mode         (cfg_mode),
    .cfg_seed         (cfg_seed),
    .cfg_pkt_len      (cfg_pkt_len),
    .m00_axis         (axis),
    .stat_fifo_level  (level),
    .stat_pkt_count   (pkt_count),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t         exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            ready_pct = 100;
  int            exp_pkts = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data;
  logic          stall_last;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pattern rules written as plain arithmetic on the value.
  function automatic logic [DW-1:0] model_next(input logic [1:0] mode, input logic [DW-1:0] d);
    case (mode)
      2'd0:    return d + 32'd1;
      2'd1:    return d - 32'd1;
      2'd2:    return (d << 1) | (d >> (DW - 1));
      default: return d;
    endcase
  endfunction

  task automatic push_packets(input logic [1:0] mode, input logic [DW-1:0] seed,
                              input logic [LW-1:0] len, input int npkts);
    int eff;
    logic [DW-1:0] d;
    beat_t b;
    eff = (len == 0) ? 1 : int'(len);
    d = seed;
    for (int p = 0; p < npkts; p++) begin
      for (int i = 0; i < eff; i++) begin
        b.data = d;
        b.last = (i == eff - 1);
        exp_q.push_back(b);
        d = model_next(mode, d);
      end
    end
    exp_pkts += npkts;
  endtask

  // One clock: sample at the falling edge, pick tready, score any handshake.
  task automatic step();
    beat_t e;
    @(negedge clk);
    if (aresetn) begin
      if (stall_prev) begin
        check_val("hold_valid", 64'(axis.tvalid), 64'd1);
        check_val("hold_data", 64'(axis.tdata), 64'(stall_data));
        check_val("hold_last", 64'(axis.tlast), 64'(stall_last));
      end
      check_val("tstrb", 64'(axis.tstrb), axis.tvalid ? 64'hF : 64'h0);
    end
    axis.tready = ($urandom_range(99) < ready_pct);
    stall_prev  = aresetn && axis.tvalid && !axis.tready;
    stall_data  = axis.tdata;
    stall_last  = axis.tlast;
    if (aresetn && axis.tvalid && axis.tready) begin
      if (exp_q.size() == 0) begin
        check_val("extra_beat", 64'(axis.tdata), 64'hDEAD_BEEF_0000_0000);
      end else begin
        e = exp_q.pop_front();
        $display("beat data=0x%08h last=%0d exp=0x%08h/%0d", axis.tdata, axis.tlast, e.data, e.last);
        check_val("tdata", 64'(axis.tdata), 64'(e.data));
        check_val("tlast", 64'(axis.tlast), 64'(e.last));
      end
    end
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || busy || axis.tvalid) && budget < 4000) begin
      step();
      budget++;
    end
    if (budget >= 4000) check_val({tag, "_timeout"}, 64'(exp_q.size()), 64'd0);
    check_val({tag, "_pkt_count"}, 64'(pkt_count), 64'(exp_pkts));
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_level"}, 64'(level), 64'd0);
  endtask

  task automatic run_pkts(input logic [1:0] mode, input logic [DW-1:0] seed,
                          input logic [LW-1:0] len, input int npkts, input int hold);
    logic [CW-1:0] base;
    int budget;
    base = pkt_count;
    push_packets(mode, seed, len, npkts);
    cfg_mode    = mode;
    cfg_seed    = seed;
    cfg_pkt_len = len;
    enable      = 1'b1;
    step();
    check_val("latency_k", 64'(axis.tvalid), 64'd0);
    cfg_seed = $urandom();
    if (npkts == 1) begin
      if (hold == 0) begin
        enable = 1'b0;
        step();
        check_val("latency_k1", 64'(axis.tvalid), 64'd1);
      end
      for (int i = 0; i < hold; i++) step();
    end else begin
      budget = 0;
      while (pkt_count != base + CW'(npkts - 1) && budget < 2000) begin
        step();
        budget++;
      end
      if (budget >= 2000) check_val("pace_timeout", 64'(pkt_count), 64'(base + CW'(npkts - 1)));
    end
    enable = 1'b0;
    drain("run");
  endtask

  task automatic fill_release(input logic [LW-1:0] len);
    ready_pct = 0;
    push_packets(2'd0, 32'd0, len, 1);
    cfg_mode = 2'd0; cfg_seed = 32'd0; cfg_pkt_len = len; enable = 1'b1;
    step();
    enable = 1'b0;
    for (int i = 0; i < 25; i++) step();
    check_val("bp_level", 64'(level), 64'(DEPTH));
    check_val("bp_valid", 64'(axis.tvalid), 64'd1);
    check_val("bp_data", 64'(axis.tdata), 64'd0);
    check_val("bp_busy", 64'(busy), (len > LW'(DEPTH)) ? 64'd1 : 64'd0);
    ready_pct = 100;
    drain("bp");
  endtask

  initial begin
    int eff, np, hold, sel;
    logic [1:0]    m;
    logic [DW-1:0] s;
    logic [LW-1:0] l;

    aresetn = 1'b0; enable = 1'b0; cfg_mode = 2'd0; cfg_seed = '0; cfg_pkt_len = '0;
    axis.tready = 1'b0;
    step(); step();
    check_val("rst_tvalid", 64'(axis.tvalid), 64'd0);
    check_val("rst_tdata", 64'(axis.tdata), 64'd0);
    check_val("rst_tstrb", 64'(axis.tstrb), 64'd0);
    check_val("rst_tlast", 64'(axis.tlast), 64'd0);
    check_val("rst_level", 64'(level), 64'd0);
    check_val("rst_pkts", 64'(pkt_count), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    aresetn = 1'b1;
    step();

    ready_pct = 100;
    run_pkts(2'd0, 32'd5, 16'd4, 1, 0);
    check_val("t1_pkts", 64'(pkt_count), 64'd1);

    fill_release(16'd16);
    fill_release(16'd24);

    run_pkts(2'd1, 32'd1, 16'd3, 1, 0);
    run_pkts(2'd2, 32'h8000_0001, 16'd3, 1, 0);

    run_pkts(2'd0, 32'h100, 16'd8, 1, 2);
    for (int i = 0; i < 5; i++) step();
    check_val("t5_no_writes", 64'(level), 64'd0);
    check_val("t5_pkts", 64'(pkt_count), 64'(exp_pkts));

    // Reset with ten words buffered and a long packet in flight.
    ready_pct = 0;
    cfg_mode = 2'd0; cfg_seed = 32'd7; cfg_pkt_len = 16'd100; enable = 1'b1;
    for (int i = 0; i < 11; i++) step();
    check_val("t6_level", 64'(level), 64'd10);
    aresetn = 1'b0; enable = 1'b0;
    step();
    check_val("t6_tvalid", 64'(axis.tvalid), 64'd0);
    check_val("t6_level0", 64'(level), 64'd0);
    check_val("t6_pkts", 64'(pkt_count), 64'd0);
    check_val("t6_busy", 64'(busy), 64'd0);
    exp_q.delete();
    exp_pkts = 0;
    aresetn = 1'b1;
    ready_pct = 100;
    step();
    run_pkts(2'd0, 32'h1234, 16'd5, 1, 0);

    for (int r = 0; r < 14; r++) begin
      m   = 2'($urandom_range(3));
      s   = $urandom();
      l   = ($urandom_range(7) == 0) ? 16'd0 : 16'($urandom_range(1, 24));
      eff = (l == 0) ? 1 : int'(l);
      np  = $urandom_range(1, 3);
      hold = (np == 1) ? $urandom_range(eff - 1) : 0;
      sel = $urandom_range(2);
      case (sel)
        0:       ready_pct = 100;
        1:       ready_pct = 60;
        default: ready_pct = 25;
      endcase
      run_pkts(m, s, l, np, hold);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
